dmem_lsu: RTL and testbench

//  Load/store unit: the initiator that drives the DataMemory port (word address, write data, write enable, read data).

---
 rtl/dmem_lsu_pkg.sv | 53 +++++
 rtl/dmem_lsu.sv | 162 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared types and lane helpers for the load/store unit.
// Sub-word merge and extract live here so the datapath stays readable.
package dmem_lsu_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_e;

   function automatic logic bad_access(input size_e sz,
                                       input logic [1:0] lane);
      logic r;
      r = 1'b0;
      unique case (sz)
         SZ_B:   r = 1'b0;
         SZ_H:   r = lane[0];
         SZ_W:   r = (lane != 2'b00);
         SZ_BAD: r = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input size_e sz,
                                              input logic [1:0] lane);
      logic [31:0] r;
      r = old;
      unique case (sz)
         SZ_B:    r[{lane, 3'b000} +: 8] = wd[7:0];
         SZ_H:    r[{lane[1], 4'b0000} +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                                input size_e sz,
                                                input logic sgn,
                                                input logic [1:0] lane);
      logic [31:0] r;
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = w[{lane[1], 4'b0000} +: 16];
      unique case (sz)
         SZ_B:    r = {{24{sgn & b[7]}}, b};
         SZ_H:    r = {{16{sgn & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit driving a word-wide DataMemory.
// Sub-word stores read the word, merge the lane, and write it back.
import dmem_lsu_pkg::*;

module dmem_lsu #(
   parameter int MEM_AW = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [MEM_AW+1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [MEM_AW-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write_enable,
   input  logic [31:0]       mem_read_data
);

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_e            state, state_n;
   logic [2:0]        cnt, cnt_n;
   logic              r_write, r_write_n;
   size_e             r_size, r_size_n;
   logic              r_sgn, r_sgn_n;
   logic [1:0]        r_lane, r_lane_n;
   logic [31:0]       r_wdata, r_wdata_n;
   logic              ready_n;
   logic              rv_n;
   logic [31:0]       rdata_n;
   logic              err_n;
   logic [MEM_AW-1:0] maddr_n;
   logic [31:0]       mwd_n;
   logic              we_n;
   size_e             in_size;

   assign in_size = size_e'(req_size);

   // Next state and next registered outputs for every FSM step.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      r_write_n = r_write;
      r_size_n  = r_size;
      r_sgn_n   = r_sgn;
      r_lane_n  = r_lane;
      r_wdata_n = r_wdata;
      ready_n   = req_ready;
      rv_n      = resp_valid;
      rdata_n   = resp_rdata;
      err_n     = resp_err;
      maddr_n   = mem_address;
      mwd_n     = mem_write_data;
      we_n      = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               r_write_n = req_write;
               r_size_n  = in_size;
               r_sgn_n   = req_signed;
               r_lane_n  = req_addr[1:0];
               r_wdata_n = req_wdata;
               ready_n   = 1'b0;
               if (bad_access(in_size, req_addr[1:0])) begin
                  state_n = RESP;
                  rv_n    = 1'b1;
                  err_n   = 1'b1;
                  rdata_n = '0;
               end else begin
                  maddr_n = req_addr[MEM_AW+1:2];
                  if (req_write && in_size == SZ_W) begin
                     state_n = WRITE;
                     mwd_n   = req_wdata;
                     we_n    = 1'b1;
                  end else begin
                     state_n = RD_WAIT;
                     cnt_n   = '0;
                  end
               end
            end
         end
         RD_WAIT: begin
            if (cnt == LAT) begin
               if (r_write) begin
                  state_n = WRITE;
                  mwd_n   = lane_merge(mem_read_data, r_wdata,
                                       r_size, r_lane);
                  we_n    = 1'b1;
               end else begin
                  state_n = RESP;
                  rv_n    = 1'b1;
                  err_n   = 1'b0;
                  rdata_n = lane_extract(mem_read_data, r_size,
                                         r_sgn, r_lane);
               end
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         WRITE: begin
            state_n = RESP;
            rv_n    = 1'b1;
            err_n   = 1'b0;
            rdata_n = '0;
         end
         RESP: begin
            if (resp_ready) begin
               state_n = IDLE;
               rv_n    = 1'b0;
               err_n   = 1'b0;
               rdata_n = '0;
               ready_n = 1'b1;
            end
         end
      endcase
   end

   // State, captured request and registered outputs; reset drops all work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         r_write          <= 1'b0;
         r_size           <= SZ_B;
         r_sgn            <= 1'b0;
         r_lane           <= '0;
         r_wdata          <= '0;
         req_ready        <= 1'b1;
         resp_valid       <= 1'b0;
         resp_rdata       <= '0;
         resp_err         <= 1'b0;
         mem_address      <= '0;
         mem_write_data   <= '0;
         mem_write_enable <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         r_write          <= r_write_n;
         r_size           <= r_size_n;
         r_sgn            <= r_sgn_n;
         r_lane           <= r_lane_n;
         r_wdata          <= r_wdata_n;
         req_ready        <= ready_n;
         resp_valid       <= rv_n;
         resp_rdata       <= rdata_n;
         resp_err         <= err_n;
         mem_address      <= maddr_n;
         mem_write_data   <= mwd_n;
         mem_write_enable <= we_n;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: drives the LSU against a word memory model and checks
// each response against a byte-level reference model of memory.
module tb_dmem_lsu;

   localparam int MEM_AW = 8;
   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] dmem    [0:255];
   logic [31:0] ref_mem [0:255];
   logic        load_mem = 1'b0;

   int          wr_total = 0;
   logic [7:0]  wr_addr  = '0;
   logic [31:0] wr_data  = '0;

   always #5 clk = ~clk;

   dmem_lsu #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable),
      .mem_read_data(mem_read_data)
   );

   // DataMemory: one-cycle synchronous read, write on strobe.
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) dmem[i] <= ref_mem[i];
      end else if (mem_write_enable) begin
         dmem[mem_address] <= mem_write_data;
      end
      mem_read_data <= dmem[mem_address];
   end

   // Strobe monitor.
   always @(posedge clk) begin
      if (mem_write_enable) begin
         wr_total <= wr_total + 1;
         wr_addr  <= mem_address;
         wr_data  <= mem_write_data;
      end
   end

   function automatic logic exp_err(input int sz, input int a);
      return (sz == 3) || (sz == 1 && a % 2 != 0) ||
             (sz == 2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] w,
                                            input int sz, input logic sgn,
                                            input int a);
      logic [31:0] v;
      if (sz == 0) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (sgn && v >= 128) v = v - 32'd256;
      end else if (sz == 1) begin
         v = (w >> (8 * (a % 4))) & 32'hFFFF;
         if (sgn && v >= 32768) v = v - 32'd65536;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input int sz, input int a);
      logic [31:0] m;
      int sh;
      m  = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFFFFFF;
      sh = 8 * (a % 4);
      return (old & ~(m << sh)) | ((wd & m) << sh);
   endfunction

   function automatic int exp_lat(input int w, input int sz, input int a);
      if (exp_err(sz, a)) return 1;
      if (w != 0 && sz == 2) return 2;
      if (w != 0) return RD_LAT + 3;
      return RD_LAT + 2;
   endfunction

   task automatic issue(input logic w, input logic [1:0] sz,
                        input logic sgn, input logic [9:0] a,
                        input logic [31:0] wd, output logic ok);
      int t;
      ok = 1'b1;
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL req_ready_timeout got %b exp 1", req_ready);
         ok = 1'b0;
         return;
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = 10'($urandom);
      req_wdata  = $urandom;
   endtask

   task automatic do_req(input logic w, input logic [1:0] sz,
                         input logic sgn, input logic [9:0] a,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int ns);
      logic ok;
      int w0;
      w0 = wr_total;
      rd = '0;
      er = 1'b0;
      lat = 0;
      ns = 0;
      issue(w, sz, sgn, a, wd, ok);
      if (!ok) return;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
      end
      if (!resp_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL resp_timeout got %b exp 1", resp_valid);
         return;
      end
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk);
      @(negedge clk);
      ns = wr_total - w0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_req_ready got %b exp 1", req_ready);
      end
      n_cmp++;
      if (resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_resp_valid got %b exp 0", resp_valid);
      end
      n_cmp++;
      if (resp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_resp_err got %b exp 0", resp_err);
      end
      n_cmp++;
      if (resp_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata);
      end
      n_cmp++;
      if (mem_address !== 8'h0) begin
         n_bad++;
         $display("FAIL rst_mem_address got %h exp 0", mem_address);
      end
      n_cmp++;
      if (mem_write_data !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_mem_wdata got %h exp 0", mem_write_data);
      end
      n_cmp++;
      if (mem_write_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mem_we got %b exp 0", mem_write_enable);
      end
   endtask

   task automatic test_loads;
      logic [31:0] rd;
      logic er;
      int lat, ns;
      do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (rd !== 32'hAABBCCDD) begin
         n_bad++;
         $display("FAIL lw0_rdata got %h exp AABBCCDD", rd);
      end
      n_cmp++;
      if (er !== 1'b0 || lat != RD_LAT + 2) begin
         n_bad++;
         $display("FAIL lw0_err_lat got %b/%0d exp 0/%0d",
                  er, lat, RD_LAT + 2);
      end
      do_req(1'b0, 2'd0, 1'b1, 10'h001, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (rd !== 32'hFFFFFFCC) begin
         n_bad++;
         $display("FAIL lb1s_rdata got %h exp FFFFFFCC", rd);
      end
      do_req(1'b0, 2'd0, 1'b0, 10'h001, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (rd !== 32'h000000CC) begin
         n_bad++;
         $display("FAIL lb1u_rdata got %h exp 000000CC", rd);
      end
      do_req(1'b0, 2'd1, 1'b1, 10'h002, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (rd !== 32'hFFFFAABB) begin
         n_bad++;
         $display("FAIL lh2s_rdata got %h exp FFFFAABB", rd);
      end
   endtask

   task automatic test_stores;
      logic [31:0] rd;
      logic er;
      int lat, ns;
      do_req(1'b1, 2'd0, 1'b0, 10'h002, 32'h11, rd, er, lat, ns);
      ref_mem[0] = ref_store(ref_mem[0], 32'h11, 0, 2);
      n_cmp++;
      if (ns != 1 || wr_addr !== 8'h00 || wr_data !== 32'hAA11CCDD) begin
         n_bad++;
         $display("FAIL sb2_strobe got %0d@%h=%h exp 1@00=AA11CCDD",
                  ns, wr_addr, wr_data);
      end
      n_cmp++;
      if (lat != RD_LAT + 3 || er !== 1'b0 || rd !== 32'h0) begin
         n_bad++;
         $display("FAIL sb2_resp got lat %0d err %b rd %h exp %0d/0/0",
                  lat, er, rd, RD_LAT + 3);
      end
      do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (rd !== 32'hAA11CCDD) begin
         n_bad++;
         $display("FAIL sb2_reread got %h exp AA11CCDD", rd);
      end
      do_req(1'b1, 2'd2, 1'b0, 10'h3FC, 32'h12345678, rd, er, lat, ns);
      ref_mem[255] = 32'h12345678;
      n_cmp++;
      if (ns != 1 || wr_addr !== 8'hFF || wr_data !== 32'h12345678) begin
         n_bad++;
         $display("FAIL sw3fc_strobe got %0d@%h=%h exp 1@FF=12345678",
                  ns, wr_addr, wr_data);
      end
      n_cmp++;
      if (lat != 2) begin
         n_bad++;
         $display("FAIL sw3fc_lat got %0d exp 2", lat);
      end
      do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (rd !== 32'h12345678) begin
         n_bad++;
         $display("FAIL sw3fc_reload got %h exp 12345678", rd);
      end
   endtask

   task automatic test_errors;
      logic [31:0] rd;
      logic er;
      int lat, ns;
      do_req(1'b0, 2'd1, 1'b0, 10'h001, 32'h0, rd, er, lat, ns);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0 || ns != 0 || lat != 1) begin
         n_bad++;
         $display("FAIL lh1_err got e%b r%h s%0d l%0d exp e1 r0 s0 l1",
                  er, rd, ns, lat);
      end
      do_req(1'b1, 2'd3, 1'b0, 10'h000, 32'hDEADBEEF, rd, er, lat, ns);
      n_cmp++;
      if (er !== 1'b1 || rd !== 32'h0 || ns != 0 || lat != 1) begin
         n_bad++;
         $display("FAIL sz3_err got e%b r%h s%0d l%0d exp e1 r0 s0 l1",
                  er, rd, ns, lat);
      end
      n_cmp++;
      if (dmem[0] !== ref_mem[0]) begin
         n_bad++;
         $display("FAIL err_mem0 got %h exp %h", dmem[0], ref_mem[0]);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, wd, ex;
      logic er, w, sgn;
      int lat, ns, sz, a, bad;
      for (int i = 0; i < 80; i++) begin
         sz  = $urandom_range(0, 3);
         a   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15)
                                           : $urandom_range(1008, 1023);
         w   = 1'($urandom);
         sgn = 1'($urandom);
         wd  = $urandom;
         do_req(w, 2'(sz), sgn, 10'(a), wd, rd, er, lat, ns);
         ex = (w || exp_err(sz, a)) ? 32'h0
              : exp_load(ref_mem[a / 4], sz, sgn, a);
         n_cmp++;
         if (rd !== ex || er !== exp_err(sz, a)) begin
            n_bad++;
            $display("FAIL rnd%0d_resp w%b sz%0d a%h got %h/%b exp %h/%b",
                     i, w, sz, a, rd, er, ex, exp_err(sz, a));
         end
         n_cmp++;
         if (lat != exp_lat(w, sz, a)) begin
            n_bad++;
            $display("FAIL rnd%0d_lat got %0d exp %0d",
                     i, lat, exp_lat(w, sz, a));
         end
         n_cmp++;
         if (ns != ((w && !exp_err(sz, a)) ? 1 : 0)) begin
            n_bad++;
            $display("FAIL rnd%0d_strobes got %0d exp %0d",
                     i, ns, (w && !exp_err(sz, a)) ? 1 : 0);
         end
         if (w && !exp_err(sz, a))
            ref_mem[a / 4] = ref_store(ref_mem[a / 4], wd, sz, a);
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) bad++;
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL rnd_memory got %0d differing words exp 0", bad);
      end
   endtask

   task automatic test_backpressure_reset;
      logic ok;
      logic [31:0] ex;
      int t, w0;
      resp_ready = 1'b0;
      ex = exp_load(ref_mem[0], 0, 1'b0, 3);
      issue(1'b0, 2'd0, 1'b0, 10'h003, 32'h0, ok);
      t = 0;
      while (ok && !resp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (resp_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_resp_valid got %b exp 1", resp_valid);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (resp_valid !== 1'b1 || resp_rdata !== ex ||
             resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold%0d got %b/%h/%b exp 1/%h/0",
                     c, resp_valid, resp_rdata, resp_err, ex);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w0 = wr_total;
      issue(1'b1, 2'd1, 1'b0, 10'h000, 32'h5555, ok);
      t = 0;
      while (ok && !mem_write_enable && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (mem_write_enable !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_we_seen got %b exp 1", mem_write_enable);
      end
      rst_n = 1'b0;
      #1;
      test_reset;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (dmem[0] !== ref_mem[0] || wr_total != w0) begin
         n_bad++;
         $display("FAIL rst_mid_mem got %h/%0d exp %h/0",
                  dmem[0], wr_total - w0, ref_mem[0]);
      end
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_idle got %b/%b exp 0/1",
                  resp_valid, req_ready);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[0] = 32'hAABBCCDD;
      load_mem = 1'b1;
      repeat (2) @(negedge clk);
      load_mem = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset;
      test_loads;
      test_stores;
      test_errors;
      test_random;
      test_backpressure_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
